// File: rtl/divider_nb.sv
`default_nettype none
// ============================================================================
// Module   : divider_nb
// Purpose  : Sequential restoring divider. Produces an N-bit quotient and
//            remainder, one quotient bit per clock, under a START/BUSY/DONE
//            handshake. Unsigned or two's-complement (truncating) operation
//            is selected by SIGNED. Divide-by-zero is flagged and short-cut.
// Ports    : CLK   - rising-edge clock
//            CLR   - asynchronous active-high reset
//            START - request, sampled on a rising edge in IDLE or FIN
//            A, B  - dividend / divisor, captured on the accepting edge
//            BUSY  - high while the iteration is running
//            DONE  - one-cycle pulse; Q, R, DIV0 valid and held from here
//            DIV0  - last operation had B == 0
//            Q, R  - quotient / remainder registers
// Revision : 1.0 - initial release
// ============================================================================
module divider_nb #(
  parameter int N      = 8,
  parameter int SIGNED = 0
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic         DIV0,
  output logic [N-1:0] Q,
  output logic [N-1:0] R
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  // Partial remainder. It always stays below |B| (< 2^N), so N bits hold it;
  // the extra bit needed for the trial subtraction lives in w_shift/w_trial.
  logic [N-1:0]  p_q, p_d;
  logic [N-1:0]  d_q, d_d;       // dividend shift register / quotient bits
  logic [N-1:0]  bmag_q, bmag_d; // divisor magnitude
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qsign_q, qsign_d;
  logic          rsign_q, rsign_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          div0_q, div0_d;

  logic          w_neg_a, w_neg_b;
  logic [N-1:0]  w_amag, w_bmag;
  logic [N:0]    w_shift, w_trial;
  logic          w_qbit;
  logic [N-1:0]  w_p_next, w_d_next;

  // Operand magnitudes; |-2^(N-1)| wraps to 2^(N-1), which is correct as unsigned.
  assign w_neg_a = (SIGNED != 0) && A[N-1];
  assign w_neg_b = (SIGNED != 0) && B[N-1];
  assign w_amag  = w_neg_a ? (-A) : A;
  assign w_bmag  = w_neg_b ? (-B) : B;

  // One restoring step. A borrow out of the (N+1)-bit subtraction means the
  // shifted remainder was smaller than the divisor.
  assign w_shift  = {p_q, d_q[N-1]};
  assign w_trial  = w_shift - {1'b0, bmag_q};
  assign w_qbit   = ~w_trial[N];
  assign w_p_next = w_qbit ? w_trial[N-1:0] : w_shift[N-1:0];
  assign w_d_next = {d_q[N-2:0], w_qbit};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    d_d     = d_q;
    bmag_d  = bmag_q;
    cnt_d   = cnt_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (START) begin
          p_d     = '0;
          d_d     = w_amag;
          bmag_d  = w_bmag;
          cnt_d   = '0;
          qsign_d = w_neg_a ^ w_neg_b;
          rsign_d = w_neg_a;
          if (B == '0) begin
            state_d = S_FIN;
            q_d     = '1;
            r_d     = A;
            div0_d  = 1'b1;
          end else begin
            state_d = S_CALC;
            div0_d  = 1'b0;
          end
        end
      end

      S_CALC: begin
        p_d   = w_p_next;
        d_d   = w_d_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_FIN;
          q_d     = qsign_q ? (-w_d_next) : w_d_next;
          r_d     = rsign_q ? (-w_p_next) : w_p_next;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      d_q     <= '0;
      bmag_q  <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      bmag_q  <= bmag_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign BUSY = (state_q == S_CALC);
  assign DONE = (state_q == S_FIN);
  assign DIV0 = div0_q;
  assign Q    = q_q;
  assign R    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_nb.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_nb
// Purpose  : Directed self-checking bench for divider_nb, N = 8. An unsigned
//            and a signed instance share the clock, reset and operand inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_nb;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] a, b;

  logic       u_busy, u_done, u_div0;
  logic [7:0] u_q, u_r;
  logic       s_busy, s_done, s_div0;
  logic [7:0] s_q, s_r;

  int total = 0;
  int bad   = 0;

  divider_nb #(.N(8), .SIGNED(0)) u_dut (
    .CLK(clk), .CLR(clr), .START(start), .A(a), .B(b),
    .BUSY(u_busy), .DONE(u_done), .DIV0(u_div0), .Q(u_q), .R(u_r)
  );

  divider_nb #(.N(8), .SIGNED(1)) s_dut (
    .CLK(clk), .CLR(clr), .START(start), .A(a), .B(b),
    .BUSY(s_busy), .DONE(s_done), .DIV0(s_div0), .Q(s_q), .R(s_r)
  );

  always #5 clk = ~clk;

  // Present operands on a falling edge, let the next rising edge accept them,
  // then drop START just after that edge.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts falling edges after the accept edge until DONE (bounded).
  // n = 1 is the cycle right after the accept edge.
  task automatic wait_done(output int n, output int busy_n);
    n = 0; busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (u_busy) busy_n++;
    end while (!u_done && n < 40);
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({u_busy, u_done, u_div0, u_q, u_r} !== 19'd0) begin
      bad++;
      $display("FAIL reset_unsigned got=%h want=0", {u_busy, u_done, u_div0, u_q, u_r});
    end
    total++;
    if ({s_busy, s_done, s_div0, s_q, s_r} !== 19'd0) begin
      bad++;
      $display("FAIL reset_signed got=%h want=0", {s_busy, s_done, s_div0, s_q, s_r});
    end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    int n, bn;
    logic [7:0] ta [4] = '{8'd200, 8'd3,  8'd255, 8'd255};
    logic [7:0] tb [4] = '{8'd7,   8'd10, 8'd1,   8'd255};
    logic [7:0] tq [4] = '{8'd28,  8'd0,  8'd255, 8'd1};
    logic [7:0] tr [4] = '{8'd4,   8'd3,  8'd0,   8'd0};
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i]);
      wait_done(n, bn);
      total++;
      if (n !== 9 || bn !== 8) begin
        bad++;
        $display("FAIL u_latency[%0d] got done_at=%0d busy=%0d want 9/8", i, n, bn);
      end
      total++;
      if ({u_q, u_r, u_div0} !== {tq[i], tr[i], 1'b0}) begin
        bad++;
        $display("FAIL u_result[%0d] got q=%0d r=%0d div0=%b want q=%0d r=%0d div0=0",
                 i, u_q, u_r, u_div0, tq[i], tr[i]);
      end
      @(negedge clk);
      total++;
      if (u_done !== 1'b0 || u_busy !== 1'b0 || u_q !== tq[i] || u_r !== tr[i]) begin
        bad++;
        $display("FAIL u_hold[%0d] got done=%b busy=%b q=%0d r=%0d want 0/0/%0d/%0d",
                 i, u_done, u_busy, u_q, u_r, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div0;
    int n, bn;
    issue(8'h55, 8'h00);
    wait_done(n, bn);
    total++;
    if (n !== 1 || bn !== 0) begin
      bad++;
      $display("FAIL div0_latency got done_at=%0d busy=%0d want 1/0", n, bn);
    end
    total++;
    if ({u_q, u_r, u_div0} !== {8'hFF, 8'h55, 1'b1}) begin
      bad++;
      $display("FAIL div0_result got q=%h r=%h div0=%b want FF/55/1", u_q, u_r, u_div0);
    end
    issue(8'd9, 8'd3);
    wait_done(n, bn);
    total++;
    if ({u_q, u_r, u_div0} !== {8'd3, 8'd0, 1'b0} || n !== 9) begin
      bad++;
      $display("FAIL div0_clear got q=%0d r=%0d div0=%b at=%0d want 3/0/0 at 9", u_q, u_r, u_div0, n);
    end
  endtask

  task automatic test_signed;
    int n, bn;
    logic [7:0] ta [5] = '{8'hF9, 8'h07, 8'hF9, 8'h80, 8'h80};
    logic [7:0] tb [5] = '{8'h02, 8'hFE, 8'hFE, 8'hFF, 8'h01};
    logic [7:0] tq [5] = '{8'hFD, 8'hFD, 8'h03, 8'h80, 8'h80};
    logic [7:0] tr [5] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i]);
      wait_done(n, bn);
      total++;
      if ({s_q, s_r, s_div0} !== {tq[i], tr[i], 1'b0} || s_done !== 1'b1) begin
        bad++;
        $display("FAIL s_result[%0d] got q=%h r=%h div0=%b done=%b want q=%h r=%h div0=0 done=1",
                 i, s_q, s_r, s_div0, s_done, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_mid_start;
    int n, bn;
    issue(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    a = 8'd50; b = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bn);
    n = n + 4;
    total++;
    if ({u_q, u_r} !== {8'd28, 8'd4} || n !== 9) begin
      bad++;
      $display("FAIL mid_start got q=%0d r=%0d done_at=%0d want 28/4 at 9", u_q, u_r, n);
    end
    @(negedge clk);
    total++;
    if (u_busy !== 1'b0 || u_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_start_idle got busy=%b done=%b want 0/0", u_busy, u_done);
    end
  endtask

  task automatic test_back_to_back;
    int n, bn;
    @(negedge clk);
    a = 8'd100; b = 8'd9; start = 1'b1;
    @(posedge clk);
    #1 a = 8'd60; b = 8'd7;
    wait_done(n, bn);
    total++;
    if ({u_q, u_r} !== {8'd11, 8'd1} || n !== 9) begin
      bad++;
      $display("FAIL b2b_first got q=%0d r=%0d done_at=%0d want 11/1 at 9", u_q, u_r, n);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, bn);
    total++;
    if (n !== 9 || bn !== 8) begin
      bad++;
      $display("FAIL b2b_latency got done_at=%0d busy=%0d want 9/8", n, bn);
    end
    total++;
    if ({u_q, u_r} !== {8'd8, 8'd4}) begin
      bad++;
      $display("FAIL b2b_second got q=%0d r=%0d want 8/4", u_q, u_r);
    end
  endtask

  task automatic test_async_reset;
    int n, bn;
    issue(8'd200, 8'd7);
    repeat (4) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    total++;
    if ({u_busy, u_done, u_div0, u_q, u_r} !== 19'd0 ||
        {s_busy, s_done, s_div0, s_q, s_r} !== 19'd0) begin
      bad++;
      $display("FAIL async_clr got u=%h s=%h want 0",
               {u_busy, u_done, u_div0, u_q, u_r}, {s_busy, s_done, s_div0, s_q, s_r});
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    total++;
    if (u_busy !== 1'b0 || u_done !== 1'b0) begin
      bad++;
      $display("FAIL clr_idle got busy=%b done=%b want 0/0", u_busy, u_done);
    end
    issue(8'd100, 8'd9);
    wait_done(n, bn);
    total++;
    if ({u_q, u_r, u_div0} !== {8'd11, 8'd1, 1'b0} || n !== 9) begin
      bad++;
      $display("FAIL after_clr got q=%0d r=%0d div0=%b at=%0d want 11/1/0 at 9", u_q, u_r, u_div0, n);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div0();
    test_signed();
    test_mid_start();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
